watch_set_ctrl: RTL and testbench
=================================

// Module: watch_set_ctrl
// PURPOSE
//  Button-driven control FSM for the watch/stopwatch display path. In watch mode it runs the
//  time-set sequence: capture live time, edit hour/min/sec with wrap, then issue a one-cycle
//  load to the watch counter. In stopwatch mode it owns run/stop and clear for the stopwatch.
//  Sits between the button debouncers and the watch/stopwatch counters; o_edit_field/o_blink
//  feed the FND controller.
// PARAMETERS
//  BLINK_HALF  50_000_000  clk cycles per o_blink half-period (0.5 s at 100 MHz)
//  TIMEOUT     1_000_000_000  idle clk cycles in a set state before abort (10 s)
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  rst           in   1  asynchronous, active-high reset
//  btn_l,btn_r   in   1  debounced single-cycle button pulses
//  btn_u,btn_d   in   1  debounced single-cycle button pulses
//  watch_mode    in   1  1 = watch selected, 0 = stopwatch selected
//  i_hour        in   5  live watch hour (0..23)
//  i_min,i_sec   in   6  live watch minute/second (0..59)
//  o_load        out  1  one-cycle strobe: watch loads o_hour/o_min/o_sec, clears msec
//  o_hour        out  5  edited hour
//  o_min,o_sec   out  6  edited minute/second
//  o_edit_field  out  2  0 none, 1 hour, 2 min, 3 sec
//  o_blink       out  1  blank-phase for the field being edited
//  sw_run        out  1  stopwatch count enable (level)
//  sw_clear      out  1  one-cycle stopwatch clear strobe
// BEHAVIOUR
//  - Reset: state RUN; all outputs 0; blink and idle counters 0.
//  - All outputs registered; response appears the cycle after the button pulse.
//  - One button acted on per cycle, priority btn_l > btn_r > btn_u > btn_d; rest dropped.
//  - States: RUN, SET_HOUR, SET_MIN, SET_SEC.
//  - RUN, watch_mode=1: btn_l -> capture i_hour/i_min/i_sec into o_*, go SET_HOUR.
//    Other buttons ignored.
//  - RUN, watch_mode=0: btn_r toggles sw_run; btn_l pulses sw_clear only if sw_run=0
//    (ignored while running); btn_u/btn_d ignored.
//  - sw_run holds its value across mode changes and set sequences.
//  - SET_*: btn_r advances field HOUR->MIN->SEC->HOUR.
//    btn_u increments current field, wrap 23->0 (hour), 59->0 (min/sec).
//    btn_d decrements, wrap 0->23 / 0->59. Other fields unchanged.
//  - SET_*: btn_l -> o_load=1 for exactly one cycle, o_* values held, state RUN.
//  - Abort (no o_load, -> RUN): watch_mode drops to 0, or idle counter reaches TIMEOUT.
//    Idle counter clears on entry and on any button pulse. Abort beats a same-cycle button.
//  - o_edit_field = 1/2/3 in SET_HOUR/MIN/SEC, 0 in RUN.
//  - o_blink: 0 in RUN; 1 on set entry and on any edit button;
//    otherwise toggles every BLINK_HALF cycles.
//  - o_hour/o_min/o_sec keep their last value in RUN; only meaningful while o_load=1.
//  - rst mid-set: immediate return to RUN, no o_load, sw_run cleared.
// STRUCTURE
//  - Package watch_ctrl_pkg: state encoding, field codes (FLD_NONE/HOUR/MIN/SEC),
//    MAX_HOUR=23, MAX_MINSEC=59.
//  - Sub-module blink_timer: BLINK_HALF-cycle counter with restart input, toggles o_blink.
//  - Idle-timeout counter and FSM stay in this module.
// TESTING (sim with BLINK_HALF=4, TIMEOUT=20)
//  - watch_mode=1, i=12:34:56, btn_l -> next cycle SET_HOUR, o_edit_field=1, o_*=12:34:56.
//    btn_u x12 -> o_hour=0; btn_d -> 23; btn_l -> o_load one cycle with 23:34:56.
//  - SET_MIN o_min=59, btn_u -> 0. btn_r twice -> SET_SEC then SET_HOUR.
//    o_sec=0, btn_d -> 59.
//  - watch_mode=0: btn_r -> sw_run=1; btn_l -> no sw_clear; btn_r -> sw_run=0;
//    btn_l -> sw_clear high exactly 1 cycle.
//  - In SET_MIN: 20 idle cycles -> RUN, o_load never 1.
//    In a separate run, watch_mode->0 mid-set -> RUN, no o_load.
//  - btn_l and btn_u same cycle in SET_HOUR -> load issued, hour not incremented.
//    o_blink period 8 cycles, restarts to 1 on btn_u.
//  - Assert rst during SET_SEC with sw_run=1 -> async return to RUN,
//    all outputs 0, o_load never asserted.

Source files
------------

// File: rtl/watch_ctrl_pkg.sv
// Shared encodings and small helpers for the watch time-set / stopwatch control path.
package watch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_HOUR = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_SEC  = 2'd3
  } field_e;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_L,
    BTN_R,
    BTN_U,
    BTN_D
  } btn_e;

  localparam logic [4:0] MAX_HOUR   = 5'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

  // Only one button is acted on per cycle: left beats right beats up beats down.
  function automatic btn_e pick_btn(input logic l, input logic r,
                                    input logic u, input logic d);
    if (l)      return BTN_L;
    else if (r) return BTN_R;
    else if (u) return BTN_U;
    else if (d) return BTN_D;
    else        return BTN_NONE;
  endfunction

  function automatic state_e next_set_state(input state_e s);
    if (s == ST_SET_HOUR)     return ST_SET_MIN;
    else if (s == ST_SET_MIN) return ST_SET_SEC;
    else                      return ST_SET_HOUR;
  endfunction

  function automatic field_e state_field(input state_e s);
    if (s == ST_SET_HOUR)     return FLD_HOUR;
    else if (s == ST_SET_MIN) return FLD_MIN;
    else if (s == ST_SET_SEC) return FLD_SEC;
    else                      return FLD_NONE;
  endfunction

  function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up);
    if (up) return (v == MAX_HOUR) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? MAX_HOUR : v - 5'd1;
  endfunction

  function automatic logic [5:0] step_minsec(input logic [5:0] v, input logic up);
    if (up) return (v == MAX_MINSEC) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? MAX_MINSEC : v - 6'd1;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blank-phase generator for the field being edited: high for BLINK_HALF cycles after
// a restart, then toggles every BLINK_HALF cycles; forced low while disabled.
module blink_timer #(
  parameter int unsigned BLINK_HALF = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_blink
);

  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_blink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else if (!i_enable) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_blink <= 1'b1;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_blink = r_blink;

endmodule

// File: rtl/watch_set_ctrl.sv
// Button-driven control for the watch time-set sequence and stopwatch run/clear.
// Every output is a register; a button's effect is visible the cycle after its pulse.
module watch_set_ctrl
  import watch_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 50_000_000,
  parameter int unsigned TIMEOUT    = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       watch_mode,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  output logic       o_load,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_edit_field,
  output logic       o_blink,
  output logic       sw_run,
  output logic       sw_clear
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  state_e            r_state;
  field_e            r_field;
  logic [4:0]        r_hour;
  logic [5:0]        r_min;
  logic [5:0]        r_sec;
  logic              r_load;
  logic              r_sw_run;
  logic              r_sw_clear;
  logic [IDLE_W-1:0] r_idle;

  btn_e       w_btn;
  logic       w_in_set;
  logic       w_abort;
  logic       w_enter;
  logic       w_edit;
  logic       w_set_next;
  logic       w_up;
  logic [4:0] w_hour_step;
  logic [5:0] w_min_step;
  logic [5:0] w_sec_step;

  assign w_btn    = pick_btn(btn_l, btn_r, btn_u, btn_d);
  assign w_in_set = (r_state != ST_RUN);
  // r_idle == IDLE_LAST means this is the TIMEOUT-th idle cycle; abort wins over any button.
  assign w_abort  = w_in_set && (!watch_mode || (r_idle == IDLE_LAST));
  assign w_enter  = !w_in_set && watch_mode && (w_btn == BTN_L);
  assign w_edit   = w_in_set && !w_abort &&
                    ((w_btn == BTN_R) || (w_btn == BTN_U) || (w_btn == BTN_D));
  assign w_set_next = w_enter || (w_in_set && !w_abort && (w_btn != BTN_L));

  assign w_up        = (w_btn == BTN_U);
  assign w_hour_step = step_hour(r_hour, w_up);
  assign w_min_step  = step_minsec(r_min, w_up);
  assign w_sec_step  = step_minsec(r_sec, w_up);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (!w_set_next || (w_btn != BTN_NONE)) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_field    <= FLD_NONE;
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_load     <= 1'b0;
      r_sw_run   <= 1'b0;
      r_sw_clear <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden later in the same block, so the
      // two strobes fall back to 0 on every cycle that does not explicitly raise them.
      r_load     <= 1'b0;
      r_sw_clear <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (watch_mode) begin
            if (w_btn == BTN_L) begin
              r_hour  <= i_hour;
              r_min   <= i_min;
              r_sec   <= i_sec;
              r_state <= ST_SET_HOUR;
              r_field <= FLD_HOUR;
            end
          end else if (w_btn == BTN_R) begin
            r_sw_run <= ~r_sw_run;
          end else if ((w_btn == BTN_L) && !r_sw_run) begin
            r_sw_clear <= 1'b1;
          end
        end
        default: begin
          if (w_abort) begin
            r_state <= ST_RUN;
            r_field <= FLD_NONE;
          end else begin
            case (w_btn)
              BTN_L: begin
                r_load  <= 1'b1;
                r_state <= ST_RUN;
                r_field <= FLD_NONE;
              end
              BTN_R: begin
                r_state <= next_set_state(r_state);
                r_field <= state_field(next_set_state(r_state));
              end
              BTN_U, BTN_D: begin
                if (r_state == ST_SET_HOUR)     r_hour <= w_hour_step;
                else if (r_state == ST_SET_MIN) r_min  <= w_min_step;
                else                            r_sec  <= w_sec_step;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  blink_timer #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (w_set_next),
    .i_restart (w_enter || w_edit),
    .o_blink   (o_blink)
  );

  assign o_load       = r_load;
  assign o_hour       = r_hour;
  assign o_min        = r_min;
  assign o_sec        = r_sec;
  assign o_edit_field = r_field;
  assign sw_run       = r_sw_run;
  assign sw_clear     = r_sw_clear;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: a driver steps a behavioural model and queues the
// expected outputs; a monitor pops one entry after every rising edge and compares.
module tb_watch_set_ctrl;

  localparam int BLINK_HALF = 4;
  localparam int TIMEOUT    = 20;
  localparam int B_NONE = 0, B_L = 1, B_R = 2, B_U = 3, B_D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       watch_mode = 1'b0;
  logic [4:0] i_hour = '0;
  logic [5:0] i_min = '0, i_sec = '0;
  logic       o_load;
  logic [4:0] o_hour;
  logic [5:0] o_min, o_sec;
  logic [1:0] o_edit_field;
  logic       o_blink, sw_run, sw_clear;

  watch_set_ctrl #(
    .BLINK_HALF (BLINK_HALF),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_l        (btn_l),
    .btn_r        (btn_r),
    .btn_u        (btn_u),
    .btn_d        (btn_d),
    .watch_mode   (watch_mode),
    .i_hour       (i_hour),
    .i_min        (i_min),
    .i_sec        (i_sec),
    .o_load       (o_load),
    .o_hour       (o_hour),
    .o_min        (o_min),
    .o_sec        (o_sec),
    .o_edit_field (o_edit_field),
    .o_blink      (o_blink),
    .sw_run       (sw_run),
    .sw_clear     (sw_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int load, hour, min, sec, fld, blink, run, clear;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cur_wm   = 1'b1;

  // Reference model: set-mode flag, field 1..3, edited time, stopwatch level,
  // idle cycles since entry/last button, cycles since last blink restart.
  bit m_set;
  int m_field, m_hour, m_min, m_sec;
  bit m_run;
  int m_idle, m_age;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out(input bit load, input bit clear);
    exp_t e;
    e.load  = int'(load);
    e.hour  = m_hour;
    e.min   = m_min;
    e.sec   = m_sec;
    e.fld   = m_set ? m_field : 0;
    e.blink = (m_set && (((m_age / BLINK_HALF) % 2) == 0)) ? 1 : 0;
    e.run   = int'(m_run);
    e.clear = int'(clear);
    return e;
  endfunction

  task automatic model_reset();
    m_set = 0; m_field = 0; m_hour = 0; m_min = 0; m_sec = 0;
    m_run = 0; m_idle = 0; m_age = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit u, input bit d,
                            input bit wm, input int h, input int mi, input int s);
    bit load = 0, clear = 0;
    int b, delta;
    b = l ? B_L : r ? B_R : u ? B_U : d ? B_D : B_NONE;
    if (!m_set) begin
      if (wm) begin
        if (b == B_L) begin
          m_hour = h; m_min = mi; m_sec = s;
          m_set = 1; m_field = 1; m_idle = 0; m_age = 0;
        end
      end else if (b == B_R) begin
        m_run = !m_run;
      end else if (b == B_L && !m_run) begin
        clear = 1;
      end
    end else if (!wm || (m_idle + 1 == TIMEOUT)) begin
      m_set = 0;
    end else if (b == B_L) begin
      load = 1;
      m_set = 0;
    end else if (b != B_NONE) begin
      m_idle = 0;
      m_age  = 0;
      if (b == B_R) begin
        m_field = m_field % 3 + 1;
      end else begin
        delta = (b == B_U) ? 1 : -1;
        if (m_field == 1)      m_hour = (m_hour + delta + 24) % 24;
        else if (m_field == 2) m_min  = (m_min + delta + 60) % 60;
        else                   m_sec  = (m_sec + delta + 60) % 60;
      end
    end else begin
      m_idle++;
      m_age++;
    end
    exp_q.push_back(model_out(load, clear));
  endtask

  // Called at a falling edge: drive one cycle of inputs, queue the expectation, wait a cycle.
  task automatic cycle_raw(input bit l, input bit r, input bit u, input bit d);
    btn_l = l; btn_r = r; btn_u = u; btn_d = d;
    watch_mode = cur_wm;
    model_step(l, r, u, d, cur_wm, int'(i_hour), int'(i_min), int'(i_sec));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle_raw(0, 0, 0, 0);
  endtask

  task automatic press(input int b);
    cycle_raw(b == B_L, b == B_R, b == B_U, b == B_D);
    idle(1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0;
    #1;
    check("async_rst_o_load",       int'(o_load), 0);
    check("async_rst_o_hour",       int'(o_hour), 0);
    check("async_rst_o_min",        int'(o_min), 0);
    check("async_rst_o_sec",        int'(o_sec), 0);
    check("async_rst_o_edit_field", int'(o_edit_field), 0);
    check("async_rst_o_blink",      int'(o_blink), 0);
    check("async_rst_sw_run",       int'(sw_run), 0);
    check("async_rst_sw_clear",     int'(sw_clear), 0);
    model_reset();
    exp_q.push_back(model_out(0, 0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("o_load",       int'(o_load), e.load);
        check("o_hour",       int'(o_hour), e.hour);
        check("o_min",        int'(o_min), e.min);
        check("o_sec",        int'(o_sec), e.sec);
        check("o_edit_field", int'(o_edit_field), e.fld);
        check("o_blink",      int'(o_blink), e.blink);
        check("sw_run",       int'(sw_run), e.run);
        check("sw_clear",     int'(sw_clear), e.clear);
      end
    end
  end

  initial begin : driver
    int rnd;
    @(negedge clk);
    apply_reset();
    idle(2);

    // Capture 12:34:56, wrap hour up through 23->0, down 0->23, then load.
    cur_wm = 1; i_hour = 5'd12; i_min = 6'd34; i_sec = 6'd56;
    press(B_L);
    for (int k = 0; k < 12; k++) press(B_U);
    press(B_D);
    press(B_L);
    idle(2);

    // Minute wrap 59->0, field cycling, second wrap 0->59.
    i_min = 6'd59; i_sec = 6'd0;
    press(B_L);
    press(B_R);
    press(B_U);
    press(B_R);
    press(B_R);
    press(B_R);
    press(B_R);
    press(B_D);
    press(B_L);
    idle(2);

    // Stopwatch: run, clear refused while running, stop, clear accepted.
    cur_wm = 0;
    idle(1);
    press(B_R);
    press(B_L);
    press(B_R);
    press(B_L);
    idle(2);

    // Idle timeout from SET_MIN.
    cur_wm = 1;
    press(B_L);
    press(B_R);
    idle(TIMEOUT + 5);

    // Mode drop mid-set.
    press(B_L);
    idle(3);
    cur_wm = 0;
    idle(2);
    cur_wm = 1;

    // Left and up in the same cycle: load wins, hour untouched.
    i_hour = 5'd7;
    press(B_L);
    cycle_raw(1, 0, 1, 0);
    idle(2);

    // Blink cadence and restart on an edit.
    press(B_L);
    idle(10);
    press(B_U);
    idle(9);
    press(B_L);

    // Reset during SET_SEC with the stopwatch running.
    cur_wm = 0;
    press(B_R);
    cur_wm = 1;
    press(B_L);
    press(B_R);
    press(B_R);
    apply_reset();
    idle(3);

    // Randomised phase.
    for (int i = 0; i < 800; i++) begin
      rnd = int'($urandom_range(0, 99));
      if ($urandom_range(0, 29) == 0) cur_wm = !cur_wm;
      i_hour = 5'($urandom_range(0, 23));
      i_min  = 6'($urandom_range(0, 59));
      i_sec  = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 249) == 0) begin
        apply_reset();
      end else if (rnd < 4) begin
        cycle_raw($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else if (rnd < 7) begin
        cycle_raw(1, 0, 0, 0);
      end else if (rnd < 10) begin
        cycle_raw(0, 1, 0, 0);
      end else if (rnd < 13) begin
        cycle_raw(0, 0, 1, 0);
      end else if (rnd < 16) begin
        cycle_raw(0, 0, 0, 1);
      end else begin
        cycle_raw(0, 0, 0, 0);
      end
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
